conv_out_tile_scheduler: RTL and testbench

CONV_OUT_TILE_SCHEDULER -- requirements
Module: conv_out_tile_scheduler

---
 rtl/conv_out_tile_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_conv_out_tile_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_tile_scheduler.sv
// ---------------------------------------------------------------------------
// conv_out_tile_scheduler
//
// Walks the output tiles of a convolution layer and hands each one to the
// quantizer / output-handler pair. Tiles are visited with output channels
// innermost, output x in the middle and output y outermost. For every tile
// the scheduler waits for the quantizer (quant_done), pulses drain_start to
// the output handler, then waits for drain_done before moving to the next
// tile. After the last tile drains it pulses layer_done.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   start                       single-cycle layer start request (IDLE only)
//   mode                        0 = 8x8 (POF_MAX0 channels/tile), 1 = 1x8 (POF_MAX1)
//   cfg_ox_num/oy_num/of_num    layer output width, height, channel count
//   quant_done                  quantizer finished the current tile
//   drain_done                  output handler finished draining the tile
//   cur_ox/oy/of_start          1-based origin of the current tile
//   cur_pox/poy/pof             tile extents clamped at the layer edge
//   drain_start                 one-cycle pulse: start draining current tile
//   busy                        high from accepted start until layer_done
//   layer_done                  one-cycle pulse after the last tile drains
//   tile_cnt                    tiles drained in the current layer
//   err_unexp                   sticky: drain_done seen outside DRAIN
// ---------------------------------------------------------------------------
module conv_out_tile_scheduler #(
   parameter int POX_MAX  = 32,
   parameter int POY_MAX  = 3,
   parameter int POF_MAX0 = 64,
   parameter int POF_MAX1 = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        mode,
   input  logic [15:0] cfg_ox_num,
   input  logic [15:0] cfg_oy_num,
   input  logic [15:0] cfg_of_num,
   input  logic        quant_done,
   input  logic        drain_done,
   output logic [15:0] cur_ox_start,
   output logic [15:0] cur_oy_start,
   output logic [15:0] cur_of_start,
   output logic [15:0] cur_pox,
   output logic [15:0] cur_poy,
   output logic [15:0] cur_pof,
   output logic        drain_start,
   output logic        busy,
   output logic        layer_done,
   output logic [15:0] tile_cnt,
   output logic        err_unexp
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WAITQ = 3'd1,
      DRAIN = 3'd2,
      NEXT  = 3'd3,
      FIN   = 3'd4
   } state_t;

   // 17-bit steps: start + step must never wrap for 16-bit dimensions.
   localparam logic [16:0] POX_STEP  = 17'(POX_MAX);
   localparam logic [16:0] POY_STEP  = 17'(POY_MAX);
   localparam logic [16:0] POF_STEP0 = 17'(POF_MAX0);
   localparam logic [16:0] POF_STEP1 = 17'(POF_MAX1);

   state_t      state_reg;
   logic        mode_reg;
   logic [16:0] ox_num_reg, oy_num_reg, of_num_reg;
   logic [16:0] ox_start_reg, oy_start_reg, of_start_reg;
   logic        pending_reg;
   logic [15:0] tile_cnt_reg;
   logic        busy_reg, drain_start_reg, layer_done_reg, err_unexp_reg;

   logic [16:0] pof_step;
   logic [16:0] ox_adv, oy_adv, of_adv;
   logic        cfg_zero;

   // Remaining extent from start to the layer edge, capped at the tile size.
   // A start beyond the edge (only possible with a zero dimension) yields 0.
   function automatic logic [15:0] clamp_ext(input logic [16:0] num,
                                             input logic [16:0] st,
                                             input logic [16:0] lim);
      logic [16:0] rem;
      if (st > num) begin
         return 16'd0;
      end
      rem = num - st + 17'd1;
      return (rem > lim) ? lim[15:0] : rem[15:0];
   endfunction

   always_comb begin
      pof_step = mode_reg ? POF_STEP1 : POF_STEP0;
      of_adv   = of_start_reg + pof_step;
      ox_adv   = ox_start_reg + POX_STEP;
      oy_adv   = oy_start_reg + POY_STEP;
      cfg_zero = (cfg_ox_num == 16'd0) || (cfg_oy_num == 16'd0) ||
                 (cfg_of_num == 16'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg       <= IDLE;
         mode_reg        <= 1'b0;
         ox_num_reg      <= 17'd0;
         oy_num_reg      <= 17'd0;
         of_num_reg      <= 17'd0;
         ox_start_reg    <= 17'd1;
         oy_start_reg    <= 17'd1;
         of_start_reg    <= 17'd1;
         pending_reg     <= 1'b0;
         tile_cnt_reg    <= 16'd0;
         busy_reg        <= 1'b0;
         drain_start_reg <= 1'b0;
         layer_done_reg  <= 1'b0;
         err_unexp_reg   <= 1'b0;
      end else begin
         drain_start_reg <= 1'b0;
         layer_done_reg  <= 1'b0;

         if (drain_done && (state_reg != DRAIN)) begin
            err_unexp_reg <= 1'b1;
         end

         case (state_reg)
            IDLE: begin
               if (start) begin
                  mode_reg     <= mode;
                  ox_num_reg   <= {1'b0, cfg_ox_num};
                  oy_num_reg   <= {1'b0, cfg_oy_num};
                  of_num_reg   <= {1'b0, cfg_of_num};
                  ox_start_reg <= 17'd1;
                  oy_start_reg <= 17'd1;
                  of_start_reg <= 17'd1;
                  tile_cnt_reg <= 16'd0;
                  pending_reg  <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= cfg_zero ? FIN : WAITQ;
               end
            end

            WAITQ: begin
               if (quant_done || pending_reg) begin
                  drain_start_reg <= 1'b1;
                  pending_reg     <= 1'b0;
                  state_reg       <= DRAIN;
               end
            end

            DRAIN: begin
               // The quantizer may already finish the next tile while this
               // one drains; remember it so WAITQ does not stall.
               if (quant_done) begin
                  pending_reg <= 1'b1;
               end
               if (drain_done) begin
                  tile_cnt_reg <= tile_cnt_reg + 16'd1;
                  state_reg    <= NEXT;
               end
            end

            NEXT: begin
               // On the final wrap the origin is left on the last tile so
               // the cur_* outputs never point past the layer.
               if (of_adv <= of_num_reg) begin
                  of_start_reg <= of_adv;
                  state_reg    <= WAITQ;
               end else if (ox_adv <= ox_num_reg) begin
                  of_start_reg <= 17'd1;
                  ox_start_reg <= ox_adv;
                  state_reg    <= WAITQ;
               end else if (oy_adv <= oy_num_reg) begin
                  of_start_reg <= 17'd1;
                  ox_start_reg <= 17'd1;
                  oy_start_reg <= oy_adv;
                  state_reg    <= WAITQ;
               end else begin
                  state_reg <= FIN;
               end
            end

            FIN: begin
               layer_done_reg <= 1'b1;
               busy_reg       <= 1'b0;
               state_reg      <= IDLE;
            end

            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   assign cur_ox_start = ox_start_reg[15:0];
   assign cur_oy_start = oy_start_reg[15:0];
   assign cur_of_start = of_start_reg[15:0];
   assign cur_pox      = clamp_ext(ox_num_reg, ox_start_reg, POX_STEP);
   assign cur_poy      = clamp_ext(oy_num_reg, oy_start_reg, POY_STEP);
   assign cur_pof      = clamp_ext(of_num_reg, of_start_reg, pof_step);
   assign drain_start  = drain_start_reg;
   assign busy         = busy_reg;
   assign layer_done   = layer_done_reg;
   assign tile_cnt     = tile_cnt_reg;
   assign err_unexp    = err_unexp_reg;

endmodule

// File: tb/tb_conv_out_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_conv_out_tile_scheduler
//
// Drives whole layers through the scheduler and checks every tile origin and
// extent against a tile list built by nested loops over the layer geometry.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_conv_out_tile_scheduler;

   localparam int PX  = 32;
   localparam int PY  = 3;
   localparam int PF0 = 64;
   localparam int PF1 = 128;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [15:0] cfg_ox_num = 16'd0;
   logic [15:0] cfg_oy_num = 16'd0;
   logic [15:0] cfg_of_num = 16'd0;
   logic        quant_done = 1'b0;
   logic        drain_done = 1'b0;
   logic [15:0] cur_ox_start, cur_oy_start, cur_of_start;
   logic [15:0] cur_pox, cur_poy, cur_pof;
   logic        drain_start, busy, layer_done, err_unexp;
   logic [15:0] tile_cnt;

   int checks = 0;
   int errors = 0;

   conv_out_tile_scheduler #(
      .POX_MAX(PX), .POY_MAX(PY), .POF_MAX0(PF0), .POF_MAX1(PF1)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .cfg_ox_num(cfg_ox_num), .cfg_oy_num(cfg_oy_num), .cfg_of_num(cfg_of_num),
      .quant_done(quant_done), .drain_done(drain_done),
      .cur_ox_start(cur_ox_start), .cur_oy_start(cur_oy_start),
      .cur_of_start(cur_of_start), .cur_pox(cur_pox), .cur_poy(cur_poy),
      .cur_pof(cur_pof), .drain_start(drain_start), .busy(busy),
      .layer_done(layer_done), .tile_cnt(tile_cnt), .err_unexp(err_unexp)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference tile list: plain nested loops over the layer, of innermost.
   typedef struct {
      int oxs, oys, ofs, px, py, pf;
   } tile_t;
   tile_t exp_q[$];

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic build_model(input bit m, input int ox, input int oy, input int of);
      tile_t t;
      int    fstep;
      fstep = m ? PF1 : PF0;
      exp_q.delete();
      for (int y = 1; y <= oy; y += PY)
         for (int x = 1; x <= ox; x += PX)
            for (int f = 1; f <= of; f += fstep) begin
               t.oxs = x;  t.oys = y;  t.ofs = f;
               t.px  = imin(PX, ox - x + 1);
               t.py  = imin(PY, oy - y + 1);
               t.pf  = imin(fstep, of - f + 1);
               exp_q.push_back(t);
            end
   endtask

   // Runs one full layer, checking each tile; reports the DUT's final tile
   // count and the last tile's extents.
   task automatic run_layer(input bit m, input int ox, input int oy, input int of,
                            output int got_cnt, output int lp, output int lq,
                            output int lf);
      int    n;
      tile_t t;
      build_model(m, ox, oy, of);
      n = exp_q.size();
      lp = 0; lq = 0; lf = 0;
      start = 1'b1; mode = m;
      cfg_ox_num = 16'(ox); cfg_oy_num = 16'(oy); cfg_of_num = 16'(of);
      cyc(1);
      start = 1'b0;
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      for (int k = 0; k < n; k++) begin
         t = exp_q[k];
         // Changes while busy must be ignored.
         mode = 1'($urandom);
         cfg_ox_num = 16'($urandom); cfg_oy_num = 16'($urandom); cfg_of_num = 16'($urandom);
         chk("ox_start", {16'd0, cur_ox_start}, t.oxs);
         chk("oy_start", {16'd0, cur_oy_start}, t.oys);
         chk("of_start", {16'd0, cur_of_start}, t.ofs);
         chk("pox", {16'd0, cur_pox}, t.px);
         chk("poy", {16'd0, cur_poy}, t.py);
         chk("pof", {16'd0, cur_pof}, t.pf);
         repeat ($urandom_range(0, 2)) begin
            cyc(1);
            chk("drain_start_idle_waitq", {31'd0, drain_start}, 32'd0);
         end
         quant_done = 1'b1;
         start = 1'($urandom);
         cyc(1);
         quant_done = 1'b0;
         start = 1'b0;
         chk("drain_start_pulse", {31'd0, drain_start}, 32'd1);
         repeat ($urandom_range(0, 2)) begin
            cyc(1);
            chk("drain_start_once", {31'd0, drain_start}, 32'd0);
            chk("pof_stable", {16'd0, cur_pof}, t.pf);
         end
         lp = cur_pox; lq = cur_poy; lf = cur_pof;
         drain_done = 1'b1;
         cyc(1);
         drain_done = 1'b0;
         chk("tile_cnt_inc", {16'd0, tile_cnt}, k + 1);
         cyc(1);
      end
      chk("layer_done_early", {31'd0, layer_done}, 32'd0);
      cyc(1);
      chk("layer_done", {31'd0, layer_done}, 32'd1);
      chk("busy_end", {31'd0, busy}, 32'd0);
      got_cnt = tile_cnt;
      cyc(1);
      chk("layer_done_one_cycle", {31'd0, layer_done}, 32'd0);
      chk("tile_cnt_hold", {16'd0, tile_cnt}, n);
      chk("err_unexp_clean", {31'd0, err_unexp}, 32'd0);
   endtask

   typedef struct {
      bit m;
      int ox, oy, of;
      int n, px, py, pf;
   } vec_t;

   initial begin
      vec_t vecs[5];
      int   cnt, lp, lq, lf;

      vecs = '{
         '{1'b0, 32, 3,  64,  1, 32, 3,  64},
         '{1'b0, 40, 4, 100,  8,  8, 1,  36},
         '{1'b1, 40, 4, 100,  4,  8, 1, 100},
         '{1'b0,  1, 1,   1,  1,  1, 1,   1},
         '{1'b1, 70, 7, 300, 27,  6, 1,  44}
      };

      // Reset state
      cyc(3);
      reset = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_drain_start", {31'd0, drain_start}, 32'd0);
      chk("rst_layer_done", {31'd0, layer_done}, 32'd0);
      chk("rst_err", {31'd0, err_unexp}, 32'd0);
      chk("rst_tile_cnt", {16'd0, tile_cnt}, 32'd0);
      chk("rst_ox_start", {16'd0, cur_ox_start}, 32'd1);
      chk("rst_oy_start", {16'd0, cur_oy_start}, 32'd1);
      chk("rst_of_start", {16'd0, cur_of_start}, 32'd1);
      chk("rst_pox", {16'd0, cur_pox}, 32'd0);
      chk("rst_poy", {16'd0, cur_poy}, 32'd0);
      chk("rst_pof", {16'd0, cur_pof}, 32'd0);

      // Table-driven layers
      for (int i = 0; i < 5; i++) begin
         run_layer(vecs[i].m, vecs[i].ox, vecs[i].oy, vecs[i].of, cnt, lp, lq, lf);
         chk("vec_tiles", cnt, vecs[i].n);
         chk("vec_last_pox", lp, vecs[i].px);
         chk("vec_last_poy", lq, vecs[i].py);
         chk("vec_last_pof", lf, vecs[i].pf);
         $display("vector %0d: mode %0d ox %0d oy %0d of %0d -> tiles %0d", i,
                  vecs[i].m, vecs[i].ox, vecs[i].oy, vecs[i].of, cnt);
      end

      // Randomized layers
      for (int i = 0; i < 5; i++) begin
         bit m;
         int ox, oy, of;
         m  = 1'($urandom);
         ox = $urandom_range(1, 80);
         oy = $urandom_range(1, 8);
         of = $urandom_range(1, 300);
         run_layer(m, ox, oy, of, cnt, lp, lq, lf);
         $display("random %0d: mode %0d ox %0d oy %0d of %0d -> tiles %0d", i, m, ox, oy, of, cnt);
      end

      // Zero-dimension layer finishes immediately with no tiles
      start = 1'b1; mode = 1'b0;
      cfg_ox_num = 16'd10; cfg_oy_num = 16'd2; cfg_of_num = 16'd0;
      cyc(1);
      start = 1'b0;
      chk("zero_busy", {31'd0, busy}, 32'd1);
      cyc(1);
      chk("zero_layer_done", {31'd0, layer_done}, 32'd1);
      chk("zero_tile_cnt", {16'd0, tile_cnt}, 32'd0);
      chk("zero_busy_end", {31'd0, busy}, 32'd0);
      $display("zero-of layer: tile_cnt %0d", tile_cnt);

      // drain_done while IDLE flags an error and leaves the state alone
      cyc(1);
      drain_done = 1'b1;
      cyc(1);
      drain_done = 1'b0;
      chk("err_idle_drain", {31'd0, err_unexp}, 32'd1);
      chk("err_no_busy", {31'd0, busy}, 32'd0);
      cyc(1);
      chk("err_sticky", {31'd0, err_unexp}, 32'd1);
      $display("idle drain_done: err_unexp %0d", err_unexp);

      // quant_done in IDLE is ignored; quant_done with drain_done sets pending
      quant_done = 1'b1;
      cyc(1);
      quant_done = 1'b0;
      start = 1'b1; mode = 1'b0;
      cfg_ox_num = 16'd40; cfg_oy_num = 16'd4; cfg_of_num = 16'd100;
      cyc(1);
      start = 1'b0;
      cyc(1);
      chk("idle_quant_ignored", {31'd0, drain_start}, 32'd0);
      cyc(1);
      chk("idle_quant_ignored2", {31'd0, drain_start}, 32'd0);
      quant_done = 1'b1;
      cyc(1);
      quant_done = 1'b0;
      chk("pend_first_drain", {31'd0, drain_start}, 32'd1);
      cyc(1);
      drain_done = 1'b1;
      quant_done = 1'b1;
      cyc(1);
      drain_done = 1'b0;
      quant_done = 1'b0;
      chk("pend_tile_cnt", {16'd0, tile_cnt}, 32'd1);
      cyc(1);
      chk("pend_of_start", {16'd0, cur_of_start}, 32'd65);
      chk("pend_pof", {16'd0, cur_pof}, 32'd36);
      cyc(1);
      chk("pend_drain_start", {31'd0, drain_start}, 32'd1);
      $display("pending: second drain_start %0d without quant_done", drain_start);

      // Reset in DRAIN aborts the layer
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_tile_cnt", {16'd0, tile_cnt}, 32'd0);
      chk("abort_ox_start", {16'd0, cur_ox_start}, 32'd1);
      chk("abort_of_start", {16'd0, cur_of_start}, 32'd1);
      chk("abort_err", {31'd0, err_unexp}, 32'd0);
      chk("abort_layer_done", {31'd0, layer_done}, 32'd0);
      cyc(1);
      chk("abort_no_layer_done", {31'd0, layer_done}, 32'd0);
      chk("abort_no_drain", {31'd0, drain_start}, 32'd0);
      $display("reset in DRAIN: busy %0d tile_cnt %0d", busy, tile_cnt);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
